// File: rtl/if_prefetch_buf_pkg.sv
// Shared instruction-fetch definitions: the NOP encoding, the default address width
// and a saturating increment helper for the optional performance counters.
package if_prefetch_buf_pkg;

    localparam int          IF_ADDR_W = 32;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/if_prefetch_buf_sync_fifo.sv
// Synchronous FIFO with a combinational head read from the storage registers.
// A flush empties it and overrides any simultaneous push or pop.
module if_prefetch_buf_sync_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok   = push && !flush && (count != CNT_W'(DEPTH));
    assign pop_ok    = pop && !flush && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer: credit-based sequential ROM fetch into a small FIFO.
// Optional IF_PREFETCH_PERF_EN adds saturating stall/flush cycle counters.
module if_prefetch_buf
    import if_prefetch_buf_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = 32 + ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              resp_kill;
    logic              issue;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic [ENT_W-1:0]  head_data;
    logic              head_valid;

    // Every outstanding request holds a FIFO slot, so a response can never overflow.
    assign occupancy  = fifo_count + CNT_W'(inflight);
    assign issue      = !rst && !jump_en_i && (occupancy < CNT_W'(DEPTH));
    assign resp_kill  = jump_en_i;
    assign fifo_push  = inflight && !resp_kill;
    assign head_valid = (fifo_count != '0);
    assign fifo_pop   = head_valid && inst_ready_i && !jump_en_i;

    assign rom_req_o    = issue;
    assign rom_addr_o   = pc;
    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head_data[ENT_W-1:ADDR_W] : INST_NOP;
    assign inst_addr_o  = head_valid ? head_data[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (jump_en_i) begin
            pc       <= {jump_addr_i[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + ADDR_W'(4);
                req_pc <= pc;
            end
        end
    end

    if_prefetch_buf_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({rom_data_i, req_pc}),
        .pop       (fifo_pop),
        .flush     (jump_en_i),
        .head_data (head_data),
        .count     (fifo_count)
    );

`ifdef IF_PREFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (jump_en_i) begin
                flush_cnt_o <= sat_inc32(flush_cnt_o);
            end else if (!head_valid) begin
                stall_cnt_o <= sat_inc32(stall_cnt_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Scoreboard bench for if_prefetch_buf: fetched PCs queue up when a request issues
// and are compared as decode accepts them. Perf counters checked with IF_PREFETCH_PERF_EN.
module tb_if_prefetch_buf;
    import if_prefetch_buf_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        inst_ready;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int          tests;
    int          failures;
    logic [31:0] sb[$];
    logic [31:0] model_pc;
    logic        inflight_m;
    int          flush_m;
    int          stall_m;

    if_prefetch_buf #(
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready)
`ifdef IF_PREFETCH_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // ROM whose word at address a holds a/4, with one cycle of registered latency.
    always @(posedge clk) begin
        if (rom_req_o) begin
            rom_data <= rom_addr_o >> 2;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", inst_valid_o, 1'b0);
        checkOutput("rst_inst", inst_o, INST_NOP);
        checkOutput("rst_addr", inst_addr_o, 32'h0);
        checkOutput("rst_req", rom_req_o, 1'b0);
        sb.delete();
        model_pc   = 32'h0;
        inflight_m = 1'b0;
        flush_m    = 0;
        stall_m    = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic jmp, input logic [31:0] tgt, input logic rdy);
        logic        valid_exp;
        logic        issue_exp;
        logic [31:0] front;
        jump_en    = jmp;
        jump_addr  = tgt;
        inst_ready = rdy;
        #1;
        valid_exp = (sb.size() - int'(inflight_m)) > 0;
        issue_exp = !jmp && (sb.size() < DEPTH);
        checkOutput("rom_req", rom_req_o, issue_exp);
        checkOutput("valid", inst_valid_o, valid_exp);
        if (valid_exp) begin
            front = sb[0];
            checkOutput("inst_addr", inst_addr_o, front);
            checkOutput("inst", inst_o, front >> 2);
        end else begin
            checkOutput("empty_inst", inst_o, INST_NOP);
            checkOutput("empty_addr", inst_addr_o, 32'h0);
        end
`ifdef IF_PREFETCH_PERF_EN
        checkOutput("flush_cnt", flush_cnt_o, 32'(flush_m));
        checkOutput("stall_cnt", stall_cnt_o, 32'(stall_m));
`endif
        if (jmp) begin
            flush_m++;
            sb.delete();
            model_pc   = tgt & 32'hFFFF_FFFC;
            inflight_m = 1'b0;
        end else begin
            if (!valid_exp) begin
                stall_m++;
            end
            if (valid_exp && rdy) begin
                void'(sb.pop_front());
            end
            if (issue_exp) begin
                checkOutput("rom_addr", rom_addr_o, model_pc);
                sb.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            inflight_m = issue_exp;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        jump_en    = 1'b0;
        jump_addr  = 32'h0;
        inst_ready = 1'b0;
        tests      = 0;
        failures   = 0;
        @(negedge clk);
        doReset();

        // Streaming fetch with decode always ready.
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Asynchronous reset in the middle of streaming.
        doReset();

        // Decode stalled: FIFO fills, requests stop, head holds, then drains.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("full_head", inst_addr_o, 32'h0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued and one request in flight.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Misaligned target, then back-to-back redirects.
        applyStimulus(1'b1, 32'h0000_0203, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0040, 1'b1);
        applyStimulus(1'b1, 32'h0000_0080, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Redirect while the head is being accepted, then PC wrap-around.
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
